// File: rtl/execute_pkg.sv
// execute_pkg: shared encodings for the MIPS EX stage (ALU ops, funct codes, control-bit indices).
package execute_pkg;
  localparam int MULT_CYC = 32;
  localparam int CW = $clog2(MULT_CYC);
  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_MUL = 6'h18;
  localparam int EX_REGDST = 3;
  localparam int EX_ALUOP = 1;
  localparam int EX_ALUSRC = 0;
  typedef enum logic [3:0] {
    SEL_AND = 4'b0000,
    SEL_OR  = 4'b0001,
    SEL_ADD = 4'b0010,
    SEL_SUB = 4'b0110,
    SEL_SLT = 4'b0111,
    SEL_MUL = 4'b1000,
    SEL_NOR = 4'b1100,
    SEL_INV = 4'b1111
  } alu_sel_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;
  function automatic alu_sel_e funct_sel(input logic [5:0] f);
    return f == F_ADD ? SEL_ADD :
           f == F_SUB ? SEL_SUB :
           f == F_AND ? SEL_AND :
           f == F_OR  ? SEL_OR  :
           f == F_NOR ? SEL_NOR :
           f == F_SLT ? SEL_SLT : SEL_INV;
  endfunction
endpackage

// File: rtl/execute_stage_ex_mem_latch.sv
// ex_mem_latch: EX/MEM pipeline register; reset or bubble loads all-zero fields.
module ex_mem_latch #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_bubble,
  input  logic [1:0]    i_wb,
  input  logic [2:0]    i_m,
  input  logic [DW-1:0] i_target,
  input  logic          i_zero,
  input  logic [DW-1:0] i_res,
  input  logic [DW-1:0] i_rd2,
  input  logic [4:0]    i_wreg,
  output logic [1:0]    o_wb,
  output logic [2:0]    o_m,
  output logic [DW-1:0] o_target,
  output logic          o_zero,
  output logic [DW-1:0] o_res,
  output logic [DW-1:0] o_rd2,
  output logic [4:0]    o_wreg
);
  always_ff @(posedge clk)
    {o_wb, o_m, o_target, o_zero, o_res, o_rd2, o_wreg} <= (rst || i_bubble) ? '0 :
      {i_wb, i_m, i_target, i_zero, i_res, i_rd2, i_wreg};
endmodule

// File: rtl/execute_stage.sv
// execute_stage: MIPS EX stage (ALU control, ALU, branch adder, dest select, EX/MEM latch).
// EX_MULT_EN adds a multi-cycle shift-add unsigned multiply on funct 0x18.
module execute_stage
  import execute_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    id_ex_wb,
  input  logic [2:0]    id_ex_mem,
  input  logic [3:0]    id_ex_execute,
  input  logic [DW-1:0] id_ex_npc,
  input  logic [DW-1:0] id_ex_readdat1,
  input  logic [DW-1:0] id_ex_readdat2,
  input  logic [DW-1:0] id_ex_sign_ext,
  input  logic [4:0]    id_ex_instr_bits_20_16,
  input  logic [4:0]    id_ex_instr_bits_15_11,
  output logic [1:0]    ex_mem_wb,
  output logic [2:0]    ex_mem_m,
  output logic [DW-1:0] ex_mem_branch_target,
  output logic          ex_mem_zero,
  output logic [DW-1:0] ex_mem_alu_result,
  output logic [DW-1:0] ex_mem_readdat2,
  output logic [4:0]    ex_mem_write_reg,
  output logic          ex_stall
);
  logic [1:0]    w_aluop;
  logic [DW-1:0] w_b, w_res, w_target, w_mul_res;
  logic [4:0]    w_wreg;
  logic          w_bubble;
  alu_sel_e      w_base, w_sel;
  assign w_aluop = id_ex_execute[EX_ALUOP +: 2];
  assign w_b = id_ex_execute[EX_ALUSRC] ? id_ex_sign_ext : id_ex_readdat2;
  assign w_wreg = id_ex_execute[EX_REGDST] ? id_ex_instr_bits_15_11 : id_ex_instr_bits_20_16;
  assign w_target = id_ex_npc + {id_ex_sign_ext[DW-3:0], 2'b00};
  assign w_base = w_aluop == ALUOP_ADD ? SEL_ADD :
                  w_aluop == ALUOP_SUB ? SEL_SUB :
                  w_aluop == ALUOP_FUNCT ? funct_sel(id_ex_sign_ext[5:0]) : SEL_INV;
`ifdef EX_MULT_EN
  logic          w_mul;
  mul_state_e    r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_mcand, r_mplier, r_prod;
  assign w_mul = w_aluop == ALUOP_FUNCT && id_ex_sign_ext[5:0] == F_MUL;
  assign w_sel = w_mul ? SEL_MUL : w_base;
  assign w_mul_res = r_prod;
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb
    w_next = r_state == IDLE ? (w_mul ? BUSY : IDLE) :
             r_state == BUSY ? (r_cnt == CW'(MULT_CYC - 1) ? DONE : BUSY) : IDLE;
  // Product is only consumed in DONE, when the latch finally loads it.
  always_comb begin
    ex_stall = w_mul && r_state != DONE;
    w_bubble = ex_stall;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_mcand <= '0;
      r_mplier <= '0;
      r_prod <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
      r_mcand <= id_ex_readdat1;
      r_mplier <= w_b;
      r_prod <= '0;
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt + CW'(1);
      r_mcand <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_prod <= r_prod + (r_mplier[0] ? r_mcand : '0);
    end
  end
`else
  assign w_sel = w_base;
  assign w_mul_res = '0;
  assign ex_stall = 1'b0;
  assign w_bubble = 1'b0;
`endif
  always_comb begin
    case (w_sel)
      SEL_AND: w_res = id_ex_readdat1 & w_b;
      SEL_OR:  w_res = id_ex_readdat1 | w_b;
      SEL_ADD: w_res = id_ex_readdat1 + w_b;
      SEL_SUB: w_res = id_ex_readdat1 - w_b;
      SEL_SLT: w_res = $signed(id_ex_readdat1) < $signed(w_b) ? DW'(1) : '0;
      SEL_NOR: w_res = ~(id_ex_readdat1 | w_b);
      SEL_MUL: w_res = w_mul_res;
      default: w_res = '0;
    endcase
  end
  ex_mem_latch #(.DW(DW)) u_latch (
    .clk     (clk),
    .rst     (rst),
    .i_bubble(w_bubble),
    .i_wb    (id_ex_wb),
    .i_m     (id_ex_mem),
    .i_target(w_target),
    .i_zero  (w_res == '0),
    .i_res   (w_res),
    .i_rd2   (id_ex_readdat2),
    .i_wreg  (w_wreg),
    .o_wb    (ex_mem_wb),
    .o_m     (ex_mem_m),
    .o_target(ex_mem_branch_target),
    .o_zero  (ex_mem_zero),
    .o_res   (ex_mem_alu_result),
    .o_rd2   (ex_mem_readdat2),
    .o_wreg  (ex_mem_write_reg)
  );
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: vector table, random model comparison, reset and multiply sequences.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_mem;
  logic [3:0]  id_ex_execute;
  logic [31:0] id_ex_npc, id_ex_readdat1, id_ex_readdat2, id_ex_sign_ext;
  logic [4:0]  id_ex_instr_bits_20_16, id_ex_instr_bits_15_11;
  logic [1:0]  ex_mem_wb;
  logic [2:0]  ex_mem_m;
  logic [31:0] ex_mem_branch_target, ex_mem_alu_result, ex_mem_readdat2;
  logic        ex_mem_zero, ex_stall;
  logic [4:0]  ex_mem_write_reg;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst(rst),
    .id_ex_wb(id_ex_wb), .id_ex_mem(id_ex_mem), .id_ex_execute(id_ex_execute),
    .id_ex_npc(id_ex_npc), .id_ex_readdat1(id_ex_readdat1), .id_ex_readdat2(id_ex_readdat2),
    .id_ex_sign_ext(id_ex_sign_ext),
    .id_ex_instr_bits_20_16(id_ex_instr_bits_20_16), .id_ex_instr_bits_15_11(id_ex_instr_bits_15_11),
    .ex_mem_wb(ex_mem_wb), .ex_mem_m(ex_mem_m), .ex_mem_branch_target(ex_mem_branch_target),
    .ex_mem_zero(ex_mem_zero), .ex_mem_alu_result(ex_mem_alu_result),
    .ex_mem_readdat2(ex_mem_readdat2), .ex_mem_write_reg(ex_mem_write_reg), .ex_stall(ex_stall)
  );

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] npc, a, rd2, imm;
    logic [4:0]  rt, rd;
  } in_t;
  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] tgt;
    logic        zero;
    logic [31:0] res, rd2;
    logic [4:0]  wreg;
  } out_t;
  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    id_ex_wb = v.wb;
    id_ex_mem = v.m;
    id_ex_execute = v.ex;
    id_ex_npc = v.npc;
    id_ex_readdat1 = v.a;
    id_ex_readdat2 = v.rd2;
    id_ex_sign_ext = v.imm;
    id_ex_instr_bits_20_16 = v.rt;
    id_ex_instr_bits_15_11 = v.rd;
  endtask

  task automatic check_out(input string tag, input out_t e);
    chk({tag, ".wb"}, 32'(ex_mem_wb), 32'(e.wb));
    chk({tag, ".m"}, 32'(ex_mem_m), 32'(e.m));
    chk({tag, ".target"}, ex_mem_branch_target, e.tgt);
    chk({tag, ".zero"}, 32'(ex_mem_zero), 32'(e.zero));
    chk({tag, ".result"}, ex_mem_alu_result, e.res);
    chk({tag, ".rd2"}, ex_mem_readdat2, e.rd2);
    chk({tag, ".write_reg"}, 32'(ex_mem_write_reg), 32'(e.wreg));
    chk({tag, ".stall"}, 32'(ex_stall), 32'd0);
  endtask

  function automatic out_t model(input in_t v);
    out_t o;
    logic [31:0] b;
    b = v.ex[0] ? v.imm : v.rd2;
    case (v.ex[2:1])
      2'b00: o.res = v.a + b;
      2'b01: o.res = v.a - b;
      2'b10:
        case (v.imm[5:0])
          6'h20: o.res = v.a + b;
          6'h22: o.res = v.a - b;
          6'h24: o.res = v.a & b;
          6'h25: o.res = v.a | b;
          6'h27: o.res = ~(v.a | b);
          6'h2A: o.res = ($signed(v.a) < $signed(b)) ? 32'd1 : 32'd0;
          default: o.res = 32'd0;
        endcase
      default: o.res = 32'd0;
    endcase
    o.zero = (o.res == 32'd0);
    o.tgt = v.npc + v.imm * 4;
    o.wreg = v.ex[3] ? v.rd : v.rt;
    o.wb = v.wb;
    o.m = v.m;
    o.rd2 = v.rd2;
    return o;
  endfunction

  vec_t tbl[12];
  in_t nop, v;
  out_t z;
  logic [5:0] fl[7];

  initial begin
    nop = '{2'b00, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0};
    z = '{2'b00, 3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 5'd0};
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F};
    tbl[0]  = '{'{2'b10, 3'b000, 4'b1100, 32'h4, 32'd5, 32'd7, 32'h20, 5'd3, 5'd9},
                '{2'b10, 3'b000, 32'h84, 1'b0, 32'd12, 32'd7, 5'd9}};
    tbl[1]  = '{'{2'b00, 3'b100, 4'b0010, 32'h100, 32'h1234, 32'h1234, 32'h3, 5'd5, 5'd0},
                '{2'b00, 3'b100, 32'h10C, 1'b1, 32'h0, 32'h1234, 5'd5}};
    tbl[2]  = '{'{2'b11, 3'b010, 4'b0001, 32'h200, 32'h1000, 32'hDEAD, 32'hFFFFFFFC, 5'd4, 5'd7},
                '{2'b11, 3'b010, 32'h1F0, 1'b0, 32'hFFC, 32'hDEAD, 5'd4}};
    tbl[3]  = '{'{2'b10, 3'b000, 4'b1100, 32'h0, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd1, 5'd2},
                '{2'b10, 3'b000, 32'hA8, 1'b0, 32'd1, 32'd1, 5'd2}};
    tbl[4]  = '{'{2'b10, 3'b000, 4'b0000, 32'h10, 32'hFFFFFFFF, 32'd1, 32'h0, 5'd6, 5'd1},
                '{2'b10, 3'b000, 32'h10, 1'b1, 32'h0, 32'd1, 5'd6}};
    tbl[5]  = '{'{2'b10, 3'b001, 4'b1100, 32'h0, 32'd5, 32'd5, 32'h3F, 5'd1, 5'd31},
                '{2'b10, 3'b001, 32'hFC, 1'b1, 32'h0, 32'd5, 5'd31}};
    tbl[6]  = '{'{2'b01, 3'b010, 4'b0110, 32'h20, 32'd9, 32'd3, 32'h20, 5'd12, 5'd13},
                '{2'b01, 3'b010, 32'hA0, 1'b1, 32'h0, 32'd3, 5'd12}};
    tbl[7]  = '{'{2'b10, 3'b000, 4'b1100, 32'h0, 32'hF0F01234, 32'h0FF0FF00, 32'h24, 5'd1, 5'd10},
                '{2'b10, 3'b000, 32'h90, 1'b0, 32'h00F01200, 32'h0FF0FF00, 5'd10}};
    tbl[8]  = '{'{2'b10, 3'b000, 4'b1100, 32'h0, 32'hF0F01234, 32'h0FF0FF00, 32'h25, 5'd1, 5'd11},
                '{2'b10, 3'b000, 32'h94, 1'b0, 32'hFFF0FF34, 32'h0FF0FF00, 5'd11}};
    tbl[9]  = '{'{2'b10, 3'b000, 4'b1100, 32'h0, 32'hF0F01234, 32'h0FF0FF00, 32'h27, 5'd1, 5'd12},
                '{2'b10, 3'b000, 32'h9C, 1'b0, 32'h000F00CB, 32'h0FF0FF00, 5'd12}};
    tbl[10] = '{'{2'b10, 3'b000, 4'b1100, 32'h0, 32'd3, 32'd5, 32'h22, 5'd1, 5'd14},
                '{2'b10, 3'b000, 32'h88, 1'b0, 32'hFFFFFFFE, 32'd5, 5'd14}};
    tbl[11] = '{'{2'b10, 3'b000, 4'b0001, 32'hFFFFFFFC, 32'h0, 32'h77, 32'h2, 5'd15, 5'd16},
                '{2'b10, 3'b000, 32'h4, 1'b0, 32'h2, 32'h77, 5'd15}};

    rst = 1'b1;
    drive(tbl[0].i);
    @(posedge clk); #1;
    check_out("reset", z);
    rst = 1'b0;

    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].i);
      @(posedge clk); #1;
      check_out($sformatf("vec%0d", k), tbl[k].o);
    end

    for (int k = 0; k < 300; k++) begin
      v.wb = 2'($urandom);
      v.m = 3'($urandom);
      v.ex = 4'($urandom);
      v.npc = $urandom;
      v.a = $urandom;
      v.rd2 = ($urandom_range(0, 3) == 0) ? v.a : $urandom;
      v.imm = $urandom;
      if ($urandom_range(0, 3) != 0) v.imm[5:0] = fl[$urandom_range(0, 6)];
      if ($urandom_range(0, 1) == 0) v.imm = {{16{v.imm[15]}}, v.imm[15:0]};
      v.rt = 5'($urandom);
      v.rd = 5'($urandom);
`ifdef EX_MULT_EN
      if (v.imm[5:0] == 6'h18) v.imm[0] = 1'b1;
`endif
      drive(v);
      @(posedge clk); #1;
      check_out($sformatf("rand%0d", k), model(v));
    end

    drive(tbl[7].i);
    rst = 1'b1;
    @(posedge clk); #1;
    check_out("midreset", z);
    rst = 1'b0;
    @(posedge clk); #1;
    check_out("resume", tbl[7].o);

`ifdef EX_MULT_EN
    begin
      in_t mv;
      int n;
      mv = '{2'b10, 3'b000, 4'b1100, 32'h40, 32'd3, 32'h10, 32'h18, 5'd1, 5'd8};
      drive(mv);
      n = 0;
      while (ex_stall && n < 100) begin
        if (n > 0) begin
          chk("mult.bubble_wb", 32'(ex_mem_wb), 32'd0);
          chk("mult.bubble_res", ex_mem_alu_result, 32'd0);
          chk("mult.bubble_wreg", 32'(ex_mem_write_reg), 32'd0);
        end
        @(posedge clk); #1;
        n++;
      end
      chk("mult.stall_cycles", n, 32'd33);
      @(posedge clk); #1;
      chk("mult.result", ex_mem_alu_result, 32'h30);
      chk("mult.zero", 32'(ex_mem_zero), 32'd0);
      chk("mult.wb", 32'(ex_mem_wb), 32'd2);
      chk("mult.write_reg", 32'(ex_mem_write_reg), 32'd8);
      chk("mult.target", ex_mem_branch_target, 32'hA0);
      drive(nop);
      @(posedge clk); #1;
      drive(mv);
      repeat (11) @(posedge clk);
      #1;
      chk("mult_rst.busy", 32'(ex_stall), 32'd1);
      rst = 1'b1;
      drive(nop);
      @(posedge clk); #1;
      chk("mult_rst.stall", 32'(ex_stall), 32'd0);
      check_out("mult_rst", z);
      rst = 1'b0;
      drive(tbl[2].i);
      @(posedge clk); #1;
      check_out("mult_rst.resume", tbl[2].o);
    end
`else
    v = tbl[0].i;
    v.imm = 32'h18;
    drive(v);
    @(posedge clk); #1;
    check_out("funct18_invalid", '{2'b10, 3'b000, 32'h64, 1'b1, 32'h0, 32'd7, 5'd9});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
